// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and state type for the UART frame decoder
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_buffer.sv
// rtl/uart_frame_buffer.sv - payload byte store, synchronous write, combinational read
module uart_frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - sync hunt, length/checksum validation and buffered release of UART frames
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [7:0]  out_len,
    output logic        err_len,
    output logic        err_chk,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [15:0] frame_count
);

    localparam int PW = $clog2(MAX_LEN) + 1;
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic          rx_valid_q;
    logic [7:0]    len_q, len_d, chk_q, chk_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    out_data_q, out_data_d, out_len_q, out_len_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          err_len_q, err_len_d, err_chk_q, err_chk_d;
    logic          err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
    logic [15:0]   frame_count_q, frame_count_d;

    logic          byte_ev, buf_we;
    logic [PW-1:0] last_idx, rd_inc;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;

    assign byte_ev   = rx_valid & ~rx_valid_q;
    assign last_idx  = PW'(len_q) - PW'(1);
    assign rd_inc    = rd_ptr_q + PW'(1);
    // Read address looks one byte ahead so out_data can be registered on the handshake.
    assign buf_raddr = (state_q == DRAIN) ? rd_inc[AW-1:0] : '0;

    uart_frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (buf_raddr),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        chk_d         = chk_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tmo_d         = tmo_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_len_d     = out_len_q;
        frame_count_d = frame_count_q;
        err_len_d     = 1'b0;
        err_chk_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        buf_we        = 1'b0;
        if (clear) begin
            state_d     = HUNT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            tmo_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_len_d   = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    tmo_d = '0;
                    if (byte_ev && rx_data == SYNC_BYTE) state_d = LEN;
                end
                LEN, PAYLOAD, CHK: begin
                    if (byte_ev) begin
                        tmo_d = '0;
                        if (state_q == LEN) begin
                            if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                                len_d    = rx_data;
                                chk_d    = rx_data;
                                wr_ptr_d = '0;
                                state_d  = PAYLOAD;
                            end else begin
                                err_len_d = 1'b1;
                                state_d   = HUNT;
                            end
                        end else if (state_q == PAYLOAD) begin
                            buf_we   = 1'b1;
                            chk_d    = chk_q ^ rx_data;
                            wr_ptr_d = wr_ptr_q + PW'(1);
                            if (wr_ptr_q == last_idx) state_d = CHK;
                        end else if (rx_data == chk_q) begin
                            state_d       = DRAIN;
                            frame_count_d = frame_count_q + 16'd1;
                            rd_ptr_d      = '0;
                            out_valid_d   = 1'b1;
                            out_data_d    = buf_rdata;
                            out_last_d    = (len_q == 8'd1);
                            out_len_d     = len_q;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = HUNT;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = HUNT;
                        tmo_d         = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                DRAIN: begin
                    tmo_d = '0;
                    if (byte_ev) err_overrun_d = 1'b1;
                    if (out_ready) begin
                        if (rd_ptr_q == last_idx) begin
                            state_d     = HUNT;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            rd_ptr_d   = rd_inc;
                            out_data_d = buf_rdata;
                            out_last_d = (rd_inc == last_idx);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            rx_valid_q    <= 1'b0;
            len_q         <= '0;
            chk_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tmo_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_len_q     <= '0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rx_valid_q    <= rx_valid;
            len_q         <= len_d;
            chk_q         <= chk_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tmo_q         <= tmo_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_len_q     <= out_len_d;
            err_len_q     <= err_len_d;
            err_chk_q     <= err_chk_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_len     = out_len_q;
    assign err_len     = err_len_q;
    assign err_chk     = err_chk_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - frame-level reference model with per-cycle compare, directed and random frames
module tb_uart_frame_decoder;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 64;

    logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
    logic        rx_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  out_data, out_len;
    logic        out_valid, out_last;
    logic        err_len, err_chk, err_timeout, err_overrun;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    uart_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_len(out_len), .err_len(err_len), .err_chk(err_chk), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .frame_count(frame_count)
    );

    int checks = 0, passed = 0;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endfunction

    // Frame-level reference: bytes collected since SYNC, a queue of bytes still to be released.
    bit            m_rxq = 1'b0, in_frame = 1'b0;
    byte unsigned  fr[$];
    byte unsigned  outq[$];
    int            idle = 0;
    logic [7:0]    exp_len = 8'h00;
    logic [15:0]   exp_fc = 16'h0000;
    bit            e_len, e_chk, e_to, e_ov;

    always @(posedge clk) begin : model
        bit ev;
        byte unsigned x;
        e_len = 0; e_chk = 0; e_to = 0; e_ov = 0;
        if (rst) begin
            m_rxq = 0; in_frame = 0; fr.delete(); outq.delete(); idle = 0; exp_len = 0; exp_fc = 0;
        end else begin
            ev = rx_valid && !m_rxq;
            m_rxq = rx_valid;
            if (clear) begin
                in_frame = 0; fr.delete(); outq.delete(); idle = 0; exp_len = 0;
            end else if (outq.size() > 0) begin
                if (ev) e_ov = 1;
                if (out_ready) void'(outq.pop_front());
            end else if (in_frame) begin
                if (ev) begin
                    idle = 0;
                    fr.push_back(rx_data);
                    if (fr.size() == 1 && (fr[0] == 0 || fr[0] > MAX_LEN)) begin
                        e_len = 1; in_frame = 0;
                    end else if (fr.size() == int'(fr[0]) + 2) begin
                        x = 0;
                        for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
                        if (x == fr[fr.size()-1]) begin
                            for (int i = 1; i <= int'(fr[0]); i++) outq.push_back(fr[i]);
                            exp_len = fr[0];
                            exp_fc  = exp_fc + 16'd1;
                        end else begin
                            e_chk = 1;
                        end
                        in_frame = 0;
                    end
                end else begin
                    idle++;
                    if (idle == TMO) begin
                        e_to = 1; in_frame = 0; idle = 0;
                    end
                end
            end else if (ev && rx_data == 8'hA5) begin
                in_frame = 1; fr.delete(); idle = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (!rst) begin
            check("out_valid", out_valid, outq.size() > 0);
            if (outq.size() > 0) begin
                check("out_data", out_data, outq[0]);
                check("out_last", out_last, outq.size() == 1);
                check("out_len", out_len, exp_len);
            end
            check("err_len", err_len, e_len);
            check("err_chk", err_chk, e_chk);
            check("err_timeout", err_timeout, e_to);
            check("err_overrun", err_overrun, e_ov);
            check("frame_count", frame_count, exp_fc);
        end
    end

    byte unsigned seen[$];
    bit           seen_last[$];
    int           seen_len = 0;
    int           n_len = 0, n_chk = 0, n_to = 0, n_ov = 0;

    always @(posedge clk) begin : monitor
        if (out_valid && out_ready) begin
            seen.push_back(out_data);
            seen_last.push_back(out_last);
            seen_len = out_len;
        end
        if (err_len) n_len++;
        if (err_chk) n_chk++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ov++;
    end

    bit rand_ready = 0;

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_bytes(input byte unsigned bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (out_valid && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_bounded", n < max_cycles, 1);
    endtask

    task automatic send_frame(input int len, input bit bad_chk, input int gap);
        byte unsigned c, b;
        c = 8'(len);
        send_byte(8'hA5, gap);
        send_byte(8'(len), gap);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            c ^= b;
            send_byte(b, gap);
        end
        if (bad_chk) c ^= 8'($urandom_range(1, 255));
        send_byte(c, gap);
    endtask

    initial begin : stimulus
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_len", out_len, 0);
        check("rst_frame_count", frame_count, 0);

        out_ready = 1'b1;
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_drain(50);
        check("t1_count", seen.size(), 3);
        check("t1_b0", seen[0], 8'h11);
        check("t1_b1", seen[1], 8'h22);
        check("t1_b2", seen[2], 8'h33);
        check("t1_last_mid", seen_last[1], 0);
        check("t1_last_end", seen_last[2], 1);
        check("t1_len", seen_len, 3);
        check("t1_fc", frame_count, 1);

        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        repeat (2) step();
        check("t2_err_chk", n_chk, 1);
        check("t2_no_out", seen.size(), 3);
        check("t2_fc", frame_count, 1);

        send_bytes('{8'hA5, 8'h00, 8'hA5, 8'h11});
        repeat (2) step();
        check("t3_err_len", n_len, 2);
        send_bytes('{8'hA5, 8'h01, 8'h7E, 8'h7F});
        wait_drain(50);
        check("t3_byte", seen[3], 8'h7E);
        check("t3_fc", frame_count, 2);

        send_bytes('{8'hA5, 8'h02, 8'hAA});
        repeat (TMO + 4) step();
        check("t4_err_to", n_to, 1);
        send_bytes('{8'hA5, 8'h01, 8'hA5, 8'hA4});
        wait_drain(50);
        check("t4_count", seen.size(), 5);
        check("t4_byte", seen[4], 8'hA5);
        check("t4_fc", frame_count, 3);

        out_ready = 1'b0;
        send_bytes('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32});
        repeat (3) step();
        check("t5_valid", out_valid, 1);
        check("t5_held", out_data, 8'h10);
        send_byte(8'h55, 2);
        check("t5_err_ov", n_ov, 1);
        check("t5_held2", out_data, 8'h10);
        out_ready = 1'b1;
        wait_drain(50);
        check("t5_b0", seen[5], 8'h10);
        check("t5_b1", seen[6], 8'h20);
        check("t5_last", seen_last[6], 1);
        check("t5_fc", frame_count, 4);

        send_bytes('{8'hA5, 8'h04, 8'h01, 8'h02});
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (TMO + 4) step();
        check("t6_clear_noerr", n_len + n_chk + n_to + n_ov, 5);
        check("t6_clear_valid", out_valid, 0);

        out_ready = 1'b0;
        send_bytes('{8'hA5, 8'h01, 8'h42, 8'h43});
        step();
        check("t6_drain_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_len", out_len, 0);
        check("t6_rst_fc", frame_count, 0);
        check("t6_rst_noerr", n_len + n_chk + n_to + n_ov, 5);

        rand_ready = 1;
        for (int it = 0; it < 80; it++) begin
            int kind, gap, len;
            kind = $urandom_range(0, 9);
            gap  = $urandom_range(1, 3);
            len  = $urandom_range(1, MAX_LEN);
            case (kind)
                0: send_byte(8'($urandom_range(0, 255)), gap);
                1: begin
                    send_byte(8'hA5, gap);
                    send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), gap);
                end
                2: send_frame(len, 1'b1, gap);
                3: begin
                    send_byte(8'hA5, gap);
                    send_byte(8'(len), gap);
                    repeat ($urandom_range(0, len)) send_byte(8'($urandom_range(0, 255)), gap);
                    repeat (TMO + 2) step();
                end
                4: begin
                    send_byte(8'hA5, gap);
                    send_byte(8'(len), gap);
                    clear = 1'b1;
                    step();
                    clear = 1'b0;
                end
                default: send_frame(len, 1'b0, gap);
            endcase
            repeat ($urandom_range(0, 12)) step();
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_drain(100);
        repeat (4) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : guard
        #2000000;
        checks++;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
